// File: rtl/uart_fifo_pkg.sv
// Shared constants and pointer arithmetic for the UART synchronous FIFO.
package uart_fifo_pkg;

  localparam int UART_FIFO_DW = 8;
  localparam int UART_FIFO_AW = 4;

  // Pointers carry a wrap bit, so the caller keeps the low AW+1 bits of the
  // difference to get the occupancy modulo 2**(AW+1).
  function automatic logic [31:0] fifo_level(input logic [31:0] wptr,
                                             input logic [31:0] rptr);
    return wptr - rptr;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DW register file: synchronous write, asynchronous read, cleared on reset.
module uart_fifo_mem #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wen_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int DEPTH = 2**AW;

  logic [DEPTH-1:0][DW-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     mem          <= '0;
    else if (wen_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/uart_sync_fifo.sv
// Parametrised show-ahead synchronous FIFO for the UART TX/RX paths.
// Define UART_FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module uart_sync_fifo
  import uart_fifo_pkg::*;
#(
  parameter int DW = UART_FIFO_DW,
  parameter int AW = UART_FIFO_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          wr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          rd_i,
  output logic [DW-1:0] rdata_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          hfull_o,
  output logic          afull_o,
  output logic          aempty_o,
  input  logic [AW:0]   afull_thr_i,
  input  logic [AW:0]   aempty_thr_i,
  output logic [AW:0]   level_o,
  output logic          ovf_o,
  output logic          udf_o,
  input  logic          err_clr_i
);

  localparam int DEPTH = 2**AW;

  logic [AW:0] wptr, rptr;
  logic [31:0] lvl_wide;
  logic        wr_acc, rd_acc;

  assign lvl_wide = fifo_level({{(31-AW){1'b0}}, wptr}, {{(31-AW){1'b0}}, rptr});
  assign level_o  = lvl_wide[AW:0];

  assign empty_o  = (level_o == '0);
  assign full_o   = (level_o == (AW+1)'(DEPTH));
  assign hfull_o  = (level_o >= (AW+1)'(DEPTH/2));
  assign afull_o  = (level_o >= afull_thr_i);
  assign aempty_o = (level_o <= aempty_thr_i);

  // Flush outranks both requests; full/empty gate the ones that survive.
  assign wr_acc = wr_i & ~full_o  & ~clr_i;
  assign rd_acc = rd_i & ~empty_o & ~clr_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clr_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
    end
  end

  uart_fifo_mem #(.DW(DW), .AW(AW)) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wen_i   (wr_acc),
    .waddr_i (wptr[AW-1:0]),
    .wdata_i (wdata_i),
    .raddr_i (rptr[AW-1:0]),
    .rdata_o (rdata_o)
  );

`ifdef UART_FIFO_ERR_FLAGS_EN
  logic unused_bits;
  assign unused_bits = ^lvl_wide[31:AW+1];

  // Set beats clear when both happen in the same cycle; flush leaves these alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_o <= 1'b0;
      udf_o <= 1'b0;
    end else begin
      if (wr_i & full_o & ~clr_i) ovf_o <= 1'b1;
      else if (err_clr_i)         ovf_o <= 1'b0;
      if (rd_i & empty_o & ~clr_i) udf_o <= 1'b1;
      else if (err_clr_i)          udf_o <= 1'b0;
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{lvl_wide[31:AW+1], err_clr_i};
  assign ovf_o = 1'b0;
  assign udf_o = 1'b0;
`endif

endmodule

// File: doc/uart_sync_fifo.md
# uart_sync_fifo

Parametrised synchronous FIFO that replaces the fixed 16x8 UART buffer in both the TX and RX paths. Width and depth are set by parameters. It provides an exact occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, and optional sticky overflow/underflow error flags. Read data is show-ahead: the head word is always visible on `rdata_o` while the FIFO is not empty.

## Interface
- `DW`, default 8, data width in bits (≥1).
- `AW`, default 4, address width; `DEPTH = 2**AW` entries (AW ≥ 2).
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `clr_i` input 1: synchronous flush, active high.
- `wr_i` input 1: write request.
- `wdata_i` input DW: write data.
- `rd_i` input 1: read request (pops the head word).
- `rdata_o` output DW: head word, show-ahead.
- `empty_o` output 1: level == 0.
- `full_o` output 1: level == DEPTH.
- `hfull_o` output 1: level ≥ DEPTH/2.
- `afull_o` output 1: level ≥ `afull_thr_i`.
- `aempty_o` output 1: level ≤ `aempty_thr_i`.
- `afull_thr_i` input AW+1: almost-full threshold, treated as quasi-static.
- `aempty_thr_i` input AW+1: almost-empty threshold, treated as quasi-static.
- `level_o` output AW+1: current occupancy, 0..DEPTH.
- `ovf_o` output 1: sticky overflow flag.
- `udf_o` output 1: sticky underflow flag.
- `err_clr_i` input 1: clears `ovf_o` and `udf_o`.

## Operation
- **Pointers.** `wptr` and `rptr` are AW+1 bits each. The low AW bits address memory; the MSB is the wrap bit. Pointers wrap modulo 2·DEPTH.
- **Occupancy.** `level = wptr - rptr`, computed modulo 2^(AW+1).
- **Write accept.** `wr_i & ~full & ~clr_i`. On accept: `mem[wptr[AW-1:0]] <= wdata_i` and `wptr` increments.
- **Read accept.** `rd_i & ~empty & ~clr_i`. On accept: `rptr` increments.
- **Simultaneous read and write.**
  - When not full and not empty, both are accepted and the level is unchanged.
  - When empty, only the write is accepted; there is no fall-through of write data in the same cycle.
  - When full, only the read is accepted; the write is dropped.
- **Flush.** `clr_i` has highest priority. On the next edge both pointers go to 0 and any write or read in that cycle is ignored. Memory contents are not cleared.
- **Read data.** `rdata_o = mem[rptr[AW-1:0]]`, combinational. It is valid only while `empty_o` is 0; its value when empty is unspecified apart from after reset.
- **Status flags.** All flags are combinational from the registered pointers and the threshold inputs.
  - Threshold 0 makes `afull_o` constantly 1.
  - A threshold > DEPTH makes `afull_o` constantly 0.
- **Error flags.**
  - `ovf_o` sets on `wr_i & full_o & ~clr_i`.
  - `udf_o` sets on `rd_i & empty_o & ~clr_i`.
  - Both clear on `err_clr_i`. If set and clear occur in the same cycle, set wins.
  - Both are unaffected by `clr_i`.

## Timing
- **Reset values.**
  - Pointers = 0 and memory = 0, so `rdata_o` = 0.
  - `level_o` = 0, `empty_o` = 1, `aempty_o` = 1 (threshold ≥ 0).
  - `full_o` = 0 and `hfull_o` = 0.
  - `afull_o` = 1 only if `afull_thr_i` = 0.
  - `ovf_o` = 0 and `udf_o` = 0.
- **Write to visibility.** Data written at edge N appears on `rdata_o` (if it is the head), and in `level_o` and the flags, after edge N. Effective latency is 1 cycle.
- **Read to next word.** A read accepted at edge N presents the next word on `rdata_o` after edge N.
- **Reset mid-operation.** Asynchronous reset returns all state to reset values immediately; in-flight accesses are lost.
- **Error flags.** `ovf_o` and `udf_o` assert 1 cycle after the offending request.

## Configuration
- **Macro:** `UART_FIFO_ERR_FLAGS_EN`.
- **Defined:** the `ovf_o`/`udf_o` sticky registers and the `err_clr_i` logic are built as described above.
- **Undefined:** `ovf_o` and `udf_o` are tied to 0, `err_clr_i` is ignored, and no flops are inferred. All other behaviour is identical.

## Structure
- **Package `uart_fifo_pkg`:**
  - default constants `UART_FIFO_DW = 8` and `UART_FIFO_AW = 4`;
  - a function that computes the level from two pointers.
- **Sub-module `uart_fifo_mem`:**
  - DEPTH×DW register file;
  - synchronous write with enable, asynchronous read;
  - async-reset to 0;
  - ports `clk`, `rst_n`, `wen_i`, `waddr_i`, `wdata_i`, `raddr_i`, `rdata_o`.
- **Top level:** pointers, flags, flush and error logic.

## Test plan
- **Reset and fill.** Reset; write 0x01..0x10 with AW=4 and `afull_thr_i` = 15. Expect: `level_o` counts 1..16, `hfull_o` rises at level 8, `afull_o` at 15, `full_o` at 16, and `rdata_o` stays 0x01 throughout.
- **Overflow.** From full, write 0xAA. Expect: level stays 16, 0xAA is not stored, and `ovf_o` = 1 next cycle (macro defined) or 0 (undefined). Then pulse `err_clr_i`; expect `ovf_o` = 0.
- **Drain and wrap.** Read 16 times. Expect `rdata_o` sequence 0x01..0x10 and `empty_o` = 1. Then write 0x55 and 0x66 so the pointers wrap past index 15; read both back in order.
- **Simultaneous access.**
  - At level 5, hold `wr_i` and `rd_i` for 10 cycles; expect level stays 5 and the data order is preserved.
  - With the FIFO empty, assert both; expect level goes to 1 and `udf_o` sets.
- **Flush.** At level 9, assert `clr_i` together with `wr_i` and `rd_i`. Expect: next cycle level = 0, `empty_o` = 1, and no error flag change.
- **Reset mid-operation.** Assert `rst_n` low mid-burst. Expect all outputs at reset values immediately, then normal operation after release.
